// File: rtl/tw_pkg.sv
// tw_pkg: shared constants and parameter helpers for the TinyWhisper CIC decimator
//   out_w_of()  : signed result width for a given order and log2 decimation ratio
//   BIT_*_VAL   : value each bitstream level represents before sign extension
//   params_ok() : legal parameter ranges, checked at elaboration by the top
package tw_pkg;
  localparam int BIT_ONE_VAL = 1;
  localparam int BIT_ZERO_VAL = -1;
  function automatic int out_w_of(input int order, input int dec_log2);
    return order * dec_log2 + 2;
  endfunction
  function automatic bit params_ok(input int channels, input int order, input int dec_log2);
    return channels >= 1 && channels <= 4 && order >= 1 && order <= 4 && dec_log2 >= 1 && dec_log2 <= 16;
  endfunction
endpackage

// File: rtl/tw_cic_chan.sv
// tw_cic_chan: one channel's integrator cascade and comb chain
//   clk, rst_n : clock, async active-low reset
//   ena        : freeze when low
//   clear      : sync flush of integrators and comb delays
//   sample     : bitstream strobe, integrators advance
//   dec        : decimation strobe, comb delays load
//   bs         : bitstream bit (1 -> +1, 0 -> -1)
//   result     : combinational comb-chain output, valid in the decimation cycle
module tw_cic_chan
  import tw_pkg::*;
#(
  parameter int ORDER = 3,
  parameter int W = 17
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ena,
  input  logic         clear,
  input  logic         sample,
  input  logic         dec,
  input  logic         bs,
  output logic [W-1:0] result
);
  logic [W-1:0] integ [ORDER];
  logic [W-1:0] integ_nxt [ORDER];
  logic [W-1:0] dly [ORDER];
  logic [W-1:0] comb_in [ORDER];
  logic [W-1:0] x;
  logic [W-1:0] acc;
  assign x = bs ? W'(BIT_ONE_VAL) : W'(BIT_ZERO_VAL);
  // Each stage adds the previous stage's old value; the comb chain takes the
  // freshly updated last integrator so the decimated sample includes this strobe.
  always_comb begin
    integ_nxt[0] = integ[0] + x;
    for (int k = 1; k < ORDER; k++) integ_nxt[k] = integ[k] + integ[k-1];
    acc = integ_nxt[ORDER-1];
    for (int k = 0; k < ORDER; k++) begin
      comb_in[k] = acc;
      acc = acc - dly[k];
    end
  end
  assign result = acc;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int k = 0; k < ORDER; k++) begin
        integ[k] <= '0;
        dly[k] <= '0;
      end
    end else if (ena) begin
      for (int k = 0; k < ORDER; k++) begin
        if (clear) begin
          integ[k] <= '0;
          dly[k] <= '0;
        end else begin
          if (sample) integ[k] <= integ_nxt[k];
          if (dec) dly[k] <= comb_in[k];
        end
      end
    end
endmodule

// File: rtl/tw_cic_decim.sv
// tw_cic_decim: multi-channel CIC decimator, 1-bit bitstreams to signed PCM
//   clk, rst_n             : clock, async active-low reset
//   ena                    : global enable, low freezes everything
//   clear                  : sync flush of filter state, counters and out_valid
//   bs_in, bs_valid        : one bitstream bit per channel and its strobe
//   out_data, out_valid    : channel-aligned results, channel c at [c*OUT_W +: OUT_W]
//   out_ready              : consumer accept
//   overrun, overrun_clr   : sticky dropped-result flag and its clear
module tw_cic_decim
  import tw_pkg::*;
#(
  parameter int CHANNELS = 2,
  parameter int ORDER = 3,
  parameter int DEC_LOG2 = 5,
  localparam int OUT_W = out_w_of(ORDER, DEC_LOG2)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ena,
  input  logic                      clear,
  input  logic [CHANNELS-1:0]       bs_in,
  input  logic                      bs_valid,
  output logic [CHANNELS*OUT_W-1:0] out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      overrun,
  input  logic                      overrun_clr
);
  if (!params_ok(CHANNELS, ORDER, DEC_LOG2)) begin : g_bad_params
    $error("tw_cic_decim: parameter out of range");
  end
  logic [DEC_LOG2-1:0]       cnt;
  logic [2:0]                warm;
  logic [CHANNELS*OUT_W-1:0] res;
  logic                      dec;
  logic                      warm_done;
  logic                      fresh;
  assign dec = bs_valid && (&cnt);
  assign warm_done = warm == 3'(ORDER);
  assign fresh = dec && warm_done;
  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    tw_cic_chan #(.ORDER(ORDER), .W(OUT_W)) u_chan (
      .clk    (clk),
      .rst_n  (rst_n),
      .ena    (ena),
      .clear  (clear),
      .sample (bs_valid),
      .dec    (dec),
      .bs     (bs_in[c]),
      .result (res[c*OUT_W +: OUT_W])
    );
  end
  // Set of overrun is placed after its clear so a coincident drop wins.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      warm <= '0;
      out_data <= '0;
      out_valid <= 1'b0;
      overrun <= 1'b0;
    end else if (ena) begin
      if (overrun_clr) overrun <= 1'b0;
      if (clear) begin
        cnt <= '0;
        warm <= '0;
        out_valid <= 1'b0;
      end else begin
        if (bs_valid) cnt <= cnt + 1'b1;
        if (dec && !warm_done) warm <= warm + 3'd1;
        if (fresh && (!out_valid || out_ready)) begin
          out_data <= res;
          out_valid <= 1'b1;
        end else if (out_valid && out_ready) out_valid <= 1'b0;
        if (fresh && out_valid && !out_ready) overrun <= 1'b1;
      end
    end
endmodule

// File: tb/tb_tw_cic_decim.sv
// tb_tw_cic_decim: directed table-driven bench for tw_cic_decim (default parameters)
module tb_tw_cic_decim;
  localparam int W = 17;
  localparam logic [W-1:0] POS = 17'h08000;
  localparam logic [W-1:0] NEG = 17'h18000;
  localparam logic [W-1:0] MIX = 17'h05940;
  typedef struct {
    string        name;
    int           k0;
    int           k1;
    int           n;
    int           nout;
    logic [W-1:0] e0;
    logic [W-1:0] e1;
  } vec_t;
  logic           clk = 0;
  logic           rst_n = 0;
  logic           ena = 0;
  logic           clear = 0;
  logic [1:0]     bs_in = 0;
  logic           bs_valid = 0;
  logic [2*W-1:0] out_data;
  logic           out_valid;
  logic           out_ready = 0;
  logic           overrun;
  logic           overrun_clr = 0;
  int             tests = 0;
  int             fails = 0;
  logic [2*W-1:0] got [$];
  vec_t           vecs [4];
  always #5 clk = ~clk;
  tw_cic_decim dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena         (ena),
    .clear       (clear),
    .bs_in       (bs_in),
    .bs_valid    (bs_valid),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .overrun     (overrun),
    .overrun_clr (overrun_clr)
  );
  always @(negedge clk) if (rst_n && ena && out_valid && out_ready) got.push_back(out_data);
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic strobe(input logic [1:0] b);
    bs_in = b;
    bs_valid = 1;
    cyc();
    bs_valid = 0;
  endtask
  task automatic strobes(input logic [1:0] b, input int n);
    for (int i = 0; i < n; i++) strobe(b);
  endtask
  task automatic do_clear();
    clear = 1;
    cyc();
    clear = 0;
    got.delete();
  endtask
  function automatic logic pat(input int kind, input int i);
    return kind == 0 ? 1'b0 : kind == 1 ? 1'b1 : (i % 2 == 0);
  endfunction
  initial begin
    vecs[0] = '{"ones", 1, 1, 128, 1, POS, POS};
    vecs[1] = '{"zeros", 0, 0, 160, 2, NEG, NEG};
    vecs[2] = '{"alt", 2, 2, 256, 5, 17'h0, 17'h0};
    vecs[3] = '{"mixed", 1, 0, 128, 1, POS, NEG};
    ena = 1;
    out_ready = 1;
    cyc();
    cyc();
    chk("reset_data", out_data, 0);
    chk("reset_valid", out_valid, 0);
    chk("reset_overrun", overrun, 0);
    rst_n = 1;
    cyc();
    strobes(2'b11, 96);
    chk("warmup_no_out_96", got.size(), 0);
    strobes(2'b11, 31);
    chk("no_valid_127", out_valid, 0);
    strobe(2'b11);
    chk("first_valid_128", out_valid, 1);
    chk("first_data_128", out_data, {POS, POS});
    cyc();
    chk("valid_pulse_falls", out_valid, 0);
    chk("first_count", got.size(), 1);
    for (int v = 0; v < 4; v++) begin
      do_clear();
      for (int i = 0; i < vecs[v].n; i++) strobe({pat(vecs[v].k1, i), pat(vecs[v].k0, i)});
      cyc();
      cyc();
      chk({vecs[v].name, "_count"}, got.size(), vecs[v].nout);
      foreach (got[j]) begin
        chk({vecs[v].name, "_ch0"}, got[j][W-1:0], vecs[v].e0);
        chk({vecs[v].name, "_ch1"}, got[j][2*W-1:W], vecs[v].e1);
      end
    end
    do_clear();
    out_ready = 0;
    strobes(2'b11, 128);
    chk("hold_valid", out_valid, 1);
    strobes(2'b00, 31);
    chk("hold_no_overrun_yet", overrun, 0);
    strobe(2'b00);
    chk("overrun_set", overrun, 1);
    chk("overrun_data_kept", out_data, {POS, POS});
    chk("overrun_valid_kept", out_valid, 1);
    overrun_clr = 1;
    cyc();
    overrun_clr = 0;
    chk("overrun_cleared", overrun, 0);
    chk("overrun_clr_valid", out_valid, 1);
    strobes(2'b00, 31);
    overrun_clr = 1;
    strobe(2'b00);
    overrun_clr = 0;
    chk("overrun_set_wins", overrun, 1);
    overrun_clr = 1;
    cyc();
    overrun_clr = 0;
    do_clear();
    chk("clear_drops_valid", out_valid, 0);
    strobes(2'b11, 128);
    strobes(2'b00, 31);
    out_ready = 1;
    strobe(2'b00);
    out_ready = 0;
    chk("same_cycle_valid", out_valid, 1);
    chk("same_cycle_data", out_data, {MIX, MIX});
    chk("same_cycle_no_overrun", overrun, 0);
    out_ready = 1;
    cyc();
    chk("same_cycle_drain", out_valid, 0);
    do_clear();
    strobes(2'b01, 49);
    clear = 1;
    strobe(2'b11);
    clear = 0;
    got.delete();
    strobes(2'b11, 127);
    chk("midclear_none_127", got.size(), 0);
    chk("midclear_valid_127", out_valid, 0);
    strobe(2'b11);
    chk("midclear_valid_128", out_valid, 1);
    chk("midclear_data_128", out_data, {POS, POS});
    do_clear();
    strobes(2'b11, 64);
    ena = 0;
    clear = 1;
    overrun_clr = 1;
    strobes(2'b00, 5);
    clear = 0;
    overrun_clr = 0;
    ena = 1;
    strobes(2'b11, 64);
    ena = 0;
    strobes(2'b00, 10);
    chk("ena_hold_valid", out_valid, 1);
    chk("ena_none_taken", got.size(), 0);
    ena = 1;
    strobes(2'b00, 32);
    cyc();
    cyc();
    chk("ena_count", got.size(), 2);
    if (got.size() == 2) begin
      chk("ena_first", got[0], {POS, POS});
      chk("ena_second", got[1], {MIX, MIX});
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/tw_cic_decim.md
Name: tw_cic_decim

Overview:
- Parametrised multi-channel CIC decimation filter for the TinyWhisper digital core.
- Converts 1-bit sigma-delta bitstreams from the analog front-end (via ua/ui_in comparators) into signed PCM words.
- Successor to the fixed single-path top: channel count, filter order and decimation ratio are generic; it adds warm-up suppression, a valid/ready output handshake and overrun detection.
- Sits between the bitstream sampler and the uo_out/uio serialiser.

Parameters:
- CHANNELS, 2: number of independent bitstream channels (1..4).
- ORDER, 3: CIC order N, i.e. integrator and comb stage count (1..4).
- DEC_LOG2, 5: log2 of decimation ratio R (R = 32 by default).
- OUT_W: derived localparam, not overridable; equals ORDER*DEC_LOG2+2 (17 by default); signed output width.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- ena  in  1  global enable; low freezes all state
- clear  in  1  synchronous flush of filter state and pending output
- bs_in  in  CHANNELS  bitstream bits, one per channel
- bs_valid  in  1  strobe; bs_in sampled when high
- out_data  out  CHANNELS*OUT_W  signed results; channel c occupies bits [c*OUT_W +: OUT_W]
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- overrun  out  1  sticky: a result was dropped
- overrun_clr  in  1  clears overrun

Behaviour:
- One clock (clk). Reset is asynchronous and active-low (rst_n).
- Reset values: all integrators, comb delays and the decimation counter are 0; warm-up counter is 0; out_data = 0; out_valid = 0; overrun = 0.
- ena = 0: every register holds its value, including out_valid and overrun; the handshake is ignored.
- Input mapping: bit 1 = +1, bit 0 = -1, sign-extended to OUT_W.
- Integrators: on each bs_valid, stage 1 += x and stage k += stage k-1 (previous-cycle values, standard cascade). Arithmetic is two's complement mod 2^OUT_W; wrap-around is intended and must not saturate.
- Decimation counter: counts bs_valid strobes 0..R-1 and wraps to 0.
- Decimation event: bs_valid high while count = R-1. The post-update last integrator value feeds the comb chain.
- Combs: y_k = in_k - delay_k, then delay_k <= in_k; ORDER stages, all mod 2^OUT_W. The whole comb chain is evaluated in the decimation cycle.
- Result register: loaded at the clock edge following the decimation event. out_valid rises 1 cycle after that event.
- Warm-up: the first ORDER decimation events after reset or clear update the combs but do not raise out_valid. The warm-up counter saturates at ORDER.
- Handshake:
  - out_valid stays high and out_data stays stable until an out_valid & out_ready cycle.
  - Accept with no new result: out_valid falls on the next edge.
  - Accept in the same cycle a new result loads: the new result is loaded and out_valid stays 1, with no bubble.
- Overrun:
  - A new result arrives while out_valid = 1 and out_ready = 0: the new result is dropped, the old data is kept, and overrun is set.
  - overrun_clr clears overrun. If overrun_clr and a set event coincide, the set wins.
- clear (when ena = 1): in one cycle, zeroes integrators, combs, decimation counter and warm-up counter, and drops out_valid. It has priority over bs_valid in the same cycle. overrun is unaffected.
- All channels share the counter, warm-up logic and handshake, so results are always channel-aligned.

Decomposition:
- Package tw_pkg holds: the OUT_W derivation function, the bit-to-±1 mapping constants, and the parameter range checks (elaboration assertions).
- Sub-module tw_cic_chan holds one channel's integrator and comb chain, with ports for sample enable, decimation strobe, clear and result. It is instantiated CHANNELS times with a generate loop.
- Top tw_cic_decim owns the decimation counter, warm-up counter, result register, handshake and overrun.

Test Plan:
- Reset, ena = 1, out_ready = 1, 128 strobes of all-ones on both channels -> exactly one out_valid pulse, 1 cycle after strobe 128; both channels = 0x08000 (+32768). Strobes 1..96 give no out_valid.
- Constant zeros for 160 strobes -> two outputs, each 0x18000 (-32768) on every channel.
- Alternating 1/0 for 256 strobes -> every visible output equals 0.
- out_ready = 0 across two decimation events -> first result held stable, overrun = 1 after the second event; then overrun_clr -> overrun = 0 with out_valid still 1.
- out_ready pulsed in the exact cycle a new result loads -> out_valid stays 1, out_data updates, no overrun.
- Assert clear mid-frame at strobe 50, then resend 128 ones -> first visible output 0x08000, arriving after the 128th strobe following clear. Also drop ena for 10 cycles mid-stream -> results are identical to the uninterrupted run.
